// File: rtl/alu_issue.sv
// RV32I integer decode into ALU function/operands, buffered by a two-entry main+skid output stage.
// ALU_ISSUE_ILLEGAL_EN: emit illegal instructions as flagged NOP entries instead of dropping them.
module alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_alu_function,
    output logic [31:0] out_operand_a,
    output logic [31:0] out_operand_b,
    output logic        out_branch,
    output logic        out_br_invert,
    output logic        out_illegal
);

    typedef enum logic [4:0] {
        ALU_NOP  = 5'd0,
        ALU_ADD  = 5'd1,
        ALU_SUB  = 5'd2,
        ALU_SLL  = 5'd3,
        ALU_SRL  = 5'd4,
        ALU_SRA  = 5'd5,
        ALU_SEQ  = 5'd6,
        ALU_SLT  = 5'd7,
        ALU_SLTU = 5'd8,
        ALU_XOR  = 5'd9,
        ALU_OR   = 5'd10,
        ALU_AND  = 5'd11
    } alu_fn_t;

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011
    } opcode_t;

    typedef struct packed {
        alu_fn_t     func;
        logic [31:0] a;
        logic [31:0] b;
        logic        branch;
        logic        inv;
        logic        illegal;
    } entry_t;

`ifdef ALU_ISSUE_ILLEGAL_EN
    localparam bit KEEP_ILLEGAL = 1'b1;
`else
    localparam bit KEEP_ILLEGAL = 1'b0;
`endif

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_i_imm;
    logic [31:0] w_s_imm;
    logic [31:0] w_u_imm;
    entry_t      w_new;
    logic        w_illegal;

    assign w_opcode = in_instr[6:0];
    assign w_f3     = in_instr[14:12];
    assign w_f7     = in_instr[31:25];
    assign w_i_imm  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_s_imm  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_u_imm  = {in_instr[31:12], 12'b0};

    always_comb begin
        w_new     = '0;
        w_illegal = 1'b0;
        if (in_instr[1:0] != 2'b11) begin
            w_illegal = 1'b1;
        end else begin
            case (w_opcode)
                OPC_OP: begin
                    w_new.a = in_rs1;
                    w_new.b = in_rs2;
                    case (w_f3)
                        3'b000:  w_new.func = (w_f7 == 7'h20) ? ALU_SUB : ALU_ADD;
                        3'b001:  w_new.func = ALU_SLL;
                        3'b010:  w_new.func = ALU_SLT;
                        3'b011:  w_new.func = ALU_SLTU;
                        3'b100:  w_new.func = ALU_XOR;
                        3'b101:  w_new.func = (w_f7 == 7'h20) ? ALU_SRA : ALU_SRL;
                        3'b110:  w_new.func = ALU_OR;
                        default: w_new.func = ALU_AND;
                    endcase
                    // funct7 0x20 is only meaningful for SUB and SRA
                    if (!((w_f7 == 7'h00) ||
                          (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101))))
                        w_illegal = 1'b1;
                end
                OPC_OP_IMM: begin
                    w_new.a = in_rs1;
                    w_new.b = w_i_imm;
                    case (w_f3)
                        3'b000:  w_new.func = ALU_ADD;
                        3'b001: begin
                            w_new.func = ALU_SLL;
                            w_new.b    = {27'b0, in_instr[24:20]};
                            if (w_f7 != 7'h00) w_illegal = 1'b1;
                        end
                        3'b010:  w_new.func = ALU_SLT;
                        3'b011:  w_new.func = ALU_SLTU;
                        3'b100:  w_new.func = ALU_XOR;
                        3'b101: begin
                            w_new.func = (w_f7 == 7'h20) ? ALU_SRA : ALU_SRL;
                            w_new.b    = {27'b0, in_instr[24:20]};
                            if (w_f7 != 7'h00 && w_f7 != 7'h20) w_illegal = 1'b1;
                        end
                        3'b110:  w_new.func = ALU_OR;
                        default: w_new.func = ALU_AND;
                    endcase
                end
                OPC_LUI: begin
                    w_new.func = ALU_ADD;
                    w_new.b    = w_u_imm;
                end
                OPC_AUIPC: begin
                    w_new.func = ALU_ADD;
                    w_new.a    = in_pc;
                    w_new.b    = w_u_imm;
                end
                OPC_LOAD: begin
                    w_new.func = ALU_ADD;
                    w_new.a    = in_rs1;
                    w_new.b    = w_i_imm;
                end
                OPC_STORE: begin
                    w_new.func = ALU_ADD;
                    w_new.a    = in_rs1;
                    w_new.b    = w_s_imm;
                end
                OPC_BRANCH: begin
                    w_new.branch = 1'b1;
                    w_new.a      = in_rs1;
                    w_new.b      = in_rs2;
                    w_new.inv    = w_f3[0];
                    case (w_f3[2:1])
                        2'b00:   w_new.func = ALU_SEQ;
                        2'b10:   w_new.func = ALU_SLT;
                        2'b11:   w_new.func = ALU_SLTU;
                        default: w_illegal  = 1'b1;
                    endcase
                end
                default: w_illegal = 1'b1;
            endcase
        end
        if (w_illegal) begin
            w_new         = '0;
            w_new.illegal = KEEP_ILLEGAL;
        end
    end

    entry_t r_m;
    entry_t r_s;
    logic   r_m_valid;
    logic   r_s_valid;
    logic   r_in_ready;
    logic   w_accept;
    logic   w_push;
    logic   w_xfer;
    logic   w_s_valid_nxt;

    assign w_accept = in_valid && r_in_ready;
    assign w_push   = w_accept && (!w_illegal || KEEP_ILLEGAL);
    assign w_xfer   = r_m_valid && out_ready;

    // skid can only be filled while main is held; in_ready is low whenever skid is occupied
    assign w_s_valid_nxt = w_xfer ? 1'b0 : ((w_push && r_m_valid) ? 1'b1 : r_s_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m        <= '0;
            r_s        <= '0;
            r_m_valid  <= 1'b0;
            r_s_valid  <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            r_in_ready <= !w_s_valid_nxt;
            r_s_valid  <= w_s_valid_nxt;
            if (w_xfer) begin
                if (r_s_valid) begin
                    r_m <= r_s;
                end else if (w_push) begin
                    r_m <= w_new;
                end else begin
                    r_m_valid <= 1'b0;
                end
            end else if (w_push) begin
                if (!r_m_valid) begin
                    r_m       <= w_new;
                    r_m_valid <= 1'b1;
                end else begin
                    r_s <= w_new;
                end
            end
        end
    end

    assign in_ready         = r_in_ready;
    assign out_valid        = r_m_valid;
    assign out_alu_function = r_m.func;
    assign out_operand_a    = r_m.a;
    assign out_operand_b    = r_m.b;
    assign out_branch       = r_m.branch;
    assign out_br_invert    = r_m.inv;

    logic w_unused;
`ifdef ALU_ISSUE_ILLEGAL_EN
    assign out_illegal = r_m.illegal;
    assign w_unused    = &{1'b0, in_instr[19:15]};
`else
    assign out_illegal = 1'b0;
    assign w_unused    = &{1'b0, in_instr[19:15], r_m.illegal};
`endif

endmodule
